// File: rtl/mct_stop_pkg.sv
// Shared state encoding and default widths for the monitor-side stop sequencer.
package mct_stop_pkg;

   localparam int CNT_W_DEF   = 16;
   localparam int BURST_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_DRAIN = 3'd1,
      ST_HALT  = 3'd2,
      ST_STEP  = 3'd3,
      ST_BURST = 3'd4
   } mct_state_e;

endpackage

// File: rtl/mct_edge_det.sv
// Falling-edge decode of the timer's active-low T12_ pulse; marks one MCT boundary.
module mct_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic t12_n,
   output logic t12
);

   logic prev_reg;

   // Resetting to 1 means a T12_ already low when reset releases still counts as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= 1'b1;
      end else begin
         prev_reg <= t12_n;
      end
   end

   assign t12 = prev_reg & ~t12_n;

endmodule

// File: rtl/mct_stop_ctrl.sv
// Stop sequencer for the a2_timer: halts, single-steps and bursts the timer on MCT
// boundaries, latches alarms and counts completed MCTs.
module mct_stop_ctrl
   import mct_stop_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic               SIM_CLK,
   input  logic               RESET_,
   input  logic               T12_,
   input  logic               MSTOP,
   input  logic               MSTEP,
   input  logic               BURST_GO,
   input  logic [BURST_W-1:0] BURST_LEN,
   input  logic               ALARM,
   input  logic               ALARM_CLR,
   output logic               STOP,
   output logic               STEP_DONE,
   output logic               ALARM_LAT,
   output logic [2:0]         STATE,
   output logic [CNT_W-1:0]   MCT_CNT
);

   logic               t12;
   mct_state_e         state_reg, state_next;
   logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
   logic               step_done_reg, step_done_next;
   logic               stop_reg;
   logic               alarm_lat_reg, alarm_lat_next;
   logic [CNT_W-1:0]   mct_cnt_reg;
   logic               alarm_any;

   mct_edge_det u_edge (
      .clk   (SIM_CLK),
      .rst_n (RESET_),
      .t12_n (T12_),
      .t12   (t12)
   );

   // Set beats clear so a fresh alarm is never lost to a coincident acknowledge.
   assign alarm_lat_next = ALARM | (alarm_lat_reg & ~ALARM_CLR);
   assign alarm_any      = alarm_lat_reg | ALARM;

   always_comb begin
      state_next     = state_reg;
      burst_cnt_next = burst_cnt_reg;
      step_done_next = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (alarm_any || MSTOP) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (t12) begin
               state_next = ST_HALT;
            end
         end
         ST_HALT: begin
            if (alarm_lat_reg) begin
               state_next = ST_HALT;
            end else if (!MSTOP) begin
               state_next = ST_RUN;
            end else if (BURST_GO && (BURST_LEN != '0)) begin
               state_next     = ST_BURST;
               burst_cnt_next = BURST_LEN;
            end else if (MSTEP) begin
               state_next = ST_STEP;
            end
         end
         ST_STEP: begin
            if (t12) begin
               state_next     = ST_HALT;
               step_done_next = ~alarm_any;
            end
         end
         ST_BURST: begin
            if (t12) begin
               burst_cnt_next = burst_cnt_reg - BURST_W'(1);
               // An alarm cuts the burst short and suppresses the completion pulse.
               if (alarm_any) begin
                  state_next = ST_HALT;
               end else if (burst_cnt_reg == BURST_W'(1)) begin
                  state_next     = ST_HALT;
                  step_done_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge SIM_CLK or negedge RESET_) begin
      if (!RESET_) begin
         state_reg     <= ST_RUN;
         burst_cnt_reg <= '0;
         step_done_reg <= 1'b0;
         stop_reg      <= 1'b0;
         alarm_lat_reg <= 1'b0;
         mct_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         burst_cnt_reg <= burst_cnt_next;
         step_done_reg <= step_done_next;
         stop_reg      <= (state_next == ST_HALT);
         alarm_lat_reg <= alarm_lat_next;
         // Only MCTs the timer actually ran (STOP low at the boundary) are counted.
         if (t12 && !stop_reg) begin
            mct_cnt_reg <= mct_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign STOP      = stop_reg;
   assign STEP_DONE = step_done_reg;
   assign ALARM_LAT = alarm_lat_reg;
   assign STATE     = state_reg;
   assign MCT_CNT   = mct_cnt_reg;

endmodule

// File: doc/mct_stop_ctrl.md
# mct_stop_ctrl

Monitor-side stop sequencer for the a2_timer. Arbitrates halt, single-MCT step, N-MCT burst and alarm requests, and drives the timer's STOP input. STOP changes only at memory-cycle (MCT) boundaries, marked by the timer's T12_ time pulse, so the timer always halts between complete MCTs. The block also keeps a running count of completed MCTs for the monitor.

## Interface
Parameters:
- CNT_W, 16, width of MCT_CNT (wraps).
- BURST_W, 8, width of BURST_LEN and the internal burst counter.

Ports:
- SIM_CLK  in  1  system clock; everything is synchronous to its rising edge.
- RESET_  in  1  asynchronous, active-low reset.
- T12_  in  1  from the timer, active-low; low during the final time pulse of each MCT; synchronous to SIM_CLK.
- MSTOP  in  1  level; monitor halt request.
- MSTEP  in  1  one-cycle pulse; run exactly one MCT while halted.
- BURST_GO  in  1  one-cycle pulse; run BURST_LEN MCTs while halted.
- BURST_LEN  in  BURST_W  burst length, sampled on BURST_GO.
- ALARM  in  1  one-cycle pulse; forces a halt and is latched.
- ALARM_CLR  in  1  one-cycle pulse; clears the alarm latch.
- STOP  out  1  to the timer's STOP input; registered.
- STEP_DONE  out  1  one-cycle pulse when a step or burst completes.
- ALARM_LAT  out  1  sticky alarm flag.
- STATE  out  3  current state encoding.
- MCT_CNT  out  CNT_W  count of completed MCTs.

## Operation
- **Boundary event (t12):**
  - t12 is true for one cycle when the previous sample of T12_ is 1 and the current T12_ is 0.
  - The previous-sample register resets to 1.
- **MCT_CNT:** increments by 1 (modulo 2^CNT_W) on every t12 that occurs while STOP = 0. A t12 that occurs while STOP = 1 is ignored.
- **Alarm latch:**
  - ALARM sets ALARM_LAT.
  - ALARM_CLR clears it.
  - If both arrive in the same cycle, set wins.
- **States:** RUN = 0, DRAIN = 1, HALT = 2, STEP = 3, BURST = 4. STOP = 1 if and only if STATE = HALT.
- **RUN:** if ALARM_LAT, ALARM or MSTOP is asserted, go to DRAIN.
- **DRAIN:** on t12, go to HALT.
- **HALT:** evaluate in priority order; the first matching condition wins:
  1. ALARM_LAT set: stay in HALT.
  2. MSTOP = 0: go to RUN.
  3. BURST_GO with BURST_LEN ≠ 0: go to BURST and load the counter with BURST_LEN.
  4. MSTEP: go to STEP.
  - BURST_GO with BURST_LEN = 0 is ignored; an MSTEP pulse in the same cycle is still honoured.
- **STEP:** on t12, go to HALT and pulse STEP_DONE.
- **BURST:** on each t12, decrement the counter. On the t12 that sees counter = 1, go to HALT and pulse STEP_DONE.
- **Requests outside their states:**
  - MSTEP or BURST_GO arriving outside HALT is dropped.
  - MSTOP falling during STEP or BURST does not abort the run; the block returns to HALT, then goes to RUN on the following cycle.
- **Alarm during STEP or BURST:** the next t12 goes to HALT immediately, regardless of the remaining count, and STEP_DONE is not pulsed.

## Timing
- **Reset (asynchronous):** STATE = RUN, STOP = 0, STEP_DONE = 0, ALARM_LAT = 0, MCT_CNT = 0, burst counter = 0. Asserting reset mid-burst or mid-halt releases the timer immediately.
- **t12 latency:** t12 is true in the cycle where T12_ is first sampled low. The state change, STOP, STEP_DONE and the MCT_CNT update all appear on the next edge, so outputs lag the T12_ falling sample by one cycle.
- **HALT → RUN:** STOP falls one cycle after MSTOP is sampled low.
- **Halt entry:** MSTOP asserted in RUN takes one cycle to reach DRAIN. STOP then rises one cycle after the next t12.
- **Simultaneous MSTOP and t12 in RUN:** that t12 is counted. The block goes to DRAIN and halts on the following t12.
- **Burst wrap:** BURST_LEN = 2^BURST_W − 1 is legal. The counter never wraps.

## Structure
- **Package mct_stop_pkg:** the state enumeration (3-bit codes above), plus CNT_W_DEF = 16 and BURST_W_DEF = 8.
- **Sub-module mct_edge_det:** T12_ previous-sample register plus the falling-edge decode; output t12.
- **Top-level contents:** the FSM, the burst counter, the alarm latch and MCT_CNT.

## Test plan
1. **Free run:** reset, MSTOP = 0, T12_ low for 1 of every 12 cycles for 5 MCTs → MCT_CNT = 5, STOP = 0, STATE = RUN.
2. **Halt:** MSTOP rises mid-MCT → STOP = 1 exactly one cycle after the next T12_ falling sample. A further T12_ edge while halted leaves MCT_CNT unchanged.
3. **Step:** while halted, pulse MSTEP → STOP = 0 next cycle. After one t12: STOP = 1, STEP_DONE = 1 for one cycle, MCT_CNT +1.
4. **Burst:** BURST_GO with BURST_LEN = 3 → exactly 3 t12 are counted, then HALT and STEP_DONE. BURST_GO with BURST_LEN = 0 → STATE stays HALT.
5. **Alarm:**
   - Alarm in RUN: ALARM pulse → halt at the next t12, ALARM_LAT = 1; MSTOP = 0 does not release.
   - Alarm mid-burst of 10 (pulsed after 2 t12): halt at the 3rd t12, no STEP_DONE.
   - Release: ALARM_CLR with MSTOP = 0 → RUN one cycle after the cycle ALARM_CLR is applied.
6. **Reset mid-burst:** drop RESET_ → STOP = 0, MCT_CNT = 0, STATE = RUN, without waiting for a clock edge.
